// File: rtl/pipe_adder_pkg.sv
// Shared helpers for pipe_adder: the per-chunk ripple result type and the
// chunk_add ripple function used by every pipeline slice.
package pipe_adder_pkg;

    localparam int unsigned MaxChunkW = 128;

    typedef struct packed {
        logic                 cout;
        logic [MaxChunkW-1:0] sum;
    } chunk_res_t;

    // Ripples the low w bits of a and b; result bits at and above w stay zero.
    function automatic chunk_res_t chunk_add(input logic [MaxChunkW-1:0] a,
                                             input logic [MaxChunkW-1:0] b,
                                             input logic                 cin,
                                             input int                   w);
        chunk_res_t res;
        logic       c;
        res = '0;
        c   = cin;
        for (int i = 0; i < int'(MaxChunkW); i++) begin
            if (i < w) begin
                res.sum[i] = a[i] ^ b[i] ^ c;
                c          = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            end
        end
        res.cout = c;
        return res;
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One pipeline slice: ripples chunk Index of the sum, forwards the carry and the
// not-yet-consumed operand bits, with a valid/ready register handshake.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int unsigned Width  = 32,
    parameter int unsigned ChunkW = 8,
    parameter int unsigned Index  = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [Width-1:0] sum_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] a_o,
    output logic [Width-1:0] b_o,
    output logic [Width-1:0] sum_o,
    output logic             carry_o
);

    typedef struct packed {
        logic [Width-1:0] a_rem;
        logic [Width-1:0] b_rem;
        logic [Width-1:0] sum;
        logic             carry;
    } payload_t;

    payload_t   pay_d;
    payload_t   pay_q;
    logic       valid_q;
    chunk_res_t res;
    logic       unused_hi;

    // Operands are kept right-aligned, so the next chunk is always in the low bits.
    always_comb begin
        res         = chunk_add(MaxChunkW'(a_i[ChunkW-1:0]), MaxChunkW'(b_i[ChunkW-1:0]),
                                carry_i, int'(ChunkW));
        pay_d.a_rem = a_i >> ChunkW;
        pay_d.b_rem = b_i >> ChunkW;
        pay_d.sum   = sum_i | (Width'(res.sum[ChunkW-1:0]) << (Index * ChunkW));
        pay_d.carry = res.cout;
    end

    assign unused_hi = |(res.sum >> ChunkW);

    assign ready_o = !valid_q || ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            if (valid_i) begin
                pay_q <= pay_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign a_o     = pay_q.a_rem;
    assign b_o     = pay_q.b_rem;
    assign sum_o   = pay_q.sum;
    assign carry_o = pay_q.carry;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined Width-bit adder built from Stages ripple slices with valid/ready flow control.
// Define PIPE_ADDER_SUB_EN to add a per-operation sub_i select computing A - B.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned Width  = 32,
    parameter int unsigned Stages = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in1_i,
    input  logic [Width-1:0] in2_i,
    input  logic             carry_i,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] sum_o,
    output logic             carry_o
);

    localparam int unsigned ChunkW = Width / Stages;

    if (Stages < 1 || Stages > Width) begin : g_bad_stages
        $error("pipe_adder: Stages must be in 1..Width");
    end
    if (Width % Stages != 0) begin : g_bad_split
        $error("pipe_adder: Width must be a multiple of Stages");
    end
    if (ChunkW > MaxChunkW) begin : g_bad_chunk
        $error("pipe_adder: chunk width exceeds MaxChunkW");
    end

    logic [Width-1:0] b_in;
    logic             c_in;

`ifdef PIPE_ADDER_SUB_EN
    // Subtraction rides the same adders as A + ~B + 1, so later stages need no sub flag.
    assign b_in = sub_i ? ~in2_i : in2_i;
    assign c_in = sub_i ? 1'b1 : carry_i;
`else
    assign b_in = in2_i;
    assign c_in = carry_i;
`endif

    logic [Stages:0]  valid_s;
    logic [Stages:0]  carry_s;
    logic [Width-1:0] a_s   [Stages+1];
    logic [Width-1:0] b_s   [Stages+1];
    logic [Width-1:0] sum_s [Stages+1];
    logic             unused_ops;

    assign valid_s[0] = in_valid_i;
    assign carry_s[0] = c_in;
    assign a_s[0]     = in1_i;
    assign b_s[0]     = b_in;
    assign sum_s[0]   = '0;

    for (genvar k = 0; k < Stages; k++) begin : g_stage
        logic ready;
        logic ready_nxt;

        if (k == Stages - 1) begin : g_tail
            assign ready_nxt = out_ready_i;
        end else begin : g_link
            assign ready_nxt = g_stage[k+1].ready;
        end

        pipe_adder_stage #(
            .Width  (Width),
            .ChunkW (ChunkW),
            .Index  (k)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .valid_i (valid_s[k]),
            .ready_o (ready),
            .a_i     (a_s[k]),
            .b_i     (b_s[k]),
            .sum_i   (sum_s[k]),
            .carry_i (carry_s[k]),
            .valid_o (valid_s[k+1]),
            .ready_i (ready_nxt),
            .a_o     (a_s[k+1]),
            .b_o     (b_s[k+1]),
            .sum_o   (sum_s[k+1]),
            .carry_o (carry_s[k+1])
        );
    end

    assign unused_ops = ^{a_s[Stages], b_s[Stages]};

    assign in_ready_o  = g_stage[0].ready;
    assign out_valid_o = valid_s[Stages];
    assign sum_o       = sum_s[Stages];
    assign carry_o     = carry_s[Stages];

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (32-bit/4-stage) plus an 8-bit/1-stage instance.
module tb_pipe_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0] in1, in2, sum;

    logic         v8, rdy8, c8, sub8, ov8, co8;
    logic [7:0]   a8, b8, sum8;

    always #5 clk = ~clk;

    pipe_adder #(.Width(W), .Stages(S)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in1_i       (in1),
        .in2_i       (in2),
        .carry_i     (cin),
`ifdef PIPE_ADDER_SUB_EN
        .sub_i       (sub),
`endif
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .carry_o     (cout)
    );

    pipe_adder #(.Width(8), .Stages(1)) dut8 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (v8),
        .in_ready_o  (rdy8),
        .in1_i       (a8),
        .in2_i       (b8),
        .carry_i     (c8),
`ifdef PIPE_ADDER_SUB_EN
        .sub_i       (sub8),
`endif
        .out_valid_o (ov8),
        .out_ready_i (1'b1),
        .sum_o       (sum8),
        .carry_o     (co8)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   extra_out = 0;
    bit   lat_check = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Push on accepted input, pop and compare on delivered output.
    exp_t         mon_e;
    logic [W:0]   mon_r;
    always begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                mon_r     = model(in1, in2, cin, sub);
                mon_e.sum   = mon_r[W-1:0];
                mon_e.carry = mon_r[W];
                mon_e.cyc   = cyc;
                mon_e.lat   = lat_check;
                sb.push_back(mon_e);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    extra_out++;
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("sum", sum, mon_e.sum);
                    check_eq("carry", cout, mon_e.carry);
                    if (mon_e.lat) check_eq("latency", cyc - mon_e.cyc, S);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, output int waited);
        in_valid = 1'b1;
        in1      = a;
        in2      = b;
        cin      = c;
        sub      = s;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready && waited < 100);
        check_eq("accepted", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check_eq("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; sub8 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_sum", sum, 0);
        check_eq("rst_carry", cout, 0);
        check_eq("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        lat_check = 1'b1;
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, n);
        idle();
        drain();
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, n);
        idle();
        drain();

        for (int i = 0; i < 16; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, n);
            check_eq("stream_ready", n, 1);
        end
        idle();
        drain();

        lat_check = 1'b0;
        out_ready = 1'b0;
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, n);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, n);
        send(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 1'b0, n);
        send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, n);
        in_valid = 1'b1; in1 = 32'h0000_0042; in2 = 32'h0000_0001; cin = 1'b1; sub = 1'b0;
        @(negedge clk);
        check_eq("bp_ready_low", in_ready, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("bp_hold_sum", sum, 32'h3333_3333);
            check_eq("bp_hold_valid", out_valid, 1);
            check_eq("bp_hold_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h0000_0042, 32'h0000_0001, 1'b1, 1'b0, n);
        idle();
        drain();

        lat_check = 1'b1;
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, n);
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, n);
        send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, n);
        idle();
        @(posedge clk);
        #1;
        check_eq("pre_rst_valid", out_valid, 1);
        check_eq("pre_rst_sum", sum, 32'h0000_0001);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", out_valid, 0);
        check_eq("rst_mid_sum", sum, 0);
        check_eq("rst_mid_carry", cout, 0);
        check_eq("rst_mid_ready", in_ready, 1);
        sb.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("post_rst_ready", in_ready, 1);
        check_eq("post_rst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, n);
        idle();
        drain();

`ifdef PIPE_ADDER_SUB_EN
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, n);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0, n);
        send(32'h0000_0009, 32'h0000_0003, 1'b0, 1'b1, n);
        idle();
        drain();
`endif

        v8 = 1'b1; a8 = 8'hF0; b8 = 8'h20; c8 = 1'b0; sub8 = 1'b0;
        @(negedge clk);
        check_eq("s1_ready", rdy8, 1);
        @(posedge clk);
        #1 v8 = 1'b0;
        @(negedge clk);
        check_eq("s1_valid", ov8, 1);
        check_eq("s1_sum", sum8, 8'h10);
        check_eq("s1_carry", co8, 1);
        @(negedge clk);
        check_eq("s1_once", ov8, 0);
`ifdef PIPE_ADDER_SUB_EN
        @(posedge clk);
        #1;
        v8 = 1'b1; a8 = 8'h05; b8 = 8'h07; c8 = 1'b0; sub8 = 1'b1;
        @(posedge clk);
        #1 v8 = 1'b0;
        @(negedge clk);
        check_eq("s1_sub_valid", ov8, 1);
        check_eq("s1_sub_sum", sum8, 8'hFE);
        check_eq("s1_sub_carry", co8, 0);
`endif

        check_eq("no_extra", extra_out, 0);
        check_eq("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
